// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN neuron blocks.
package snn_pkg;

  typedef enum logic {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } state_e;

  // Width that holds the sum of n_in unsigned dw-bit lanes without overflow.
  function automatic int sum_w(input int n_in, input int dw);
    return dw + ((n_in > 1) ? $clog2(n_in) : 0);
  endfunction

  // Unsigned a+b clamped to 2^w-1. Works for w up to 31.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/snn_adder_tree.sv
// Combinational unsigned summer over N_IN packed DW-bit lanes.
module snn_adder_tree #(
  parameter int N_IN  = 4,
  parameter int DW    = 8,
  parameter int SUM_W = snn_pkg::sum_w(N_IN, DW)
) (
  input  logic [N_IN*DW-1:0] data_i,
  output logic [SUM_W-1:0]   sum_o
);

  logic [N_IN-1:0][DW-1:0] lane;
  assign lane = data_i;

  always_comb begin
    sum_o = '0;
    for (int k = 0; k < N_IN; k++) sum_o = sum_o + SUM_W'(lane[k]);
  end

endmodule

// File: rtl/lif_output_neuron.sv
// Leaky integrate-and-fire output neuron with refractory period and saturating spike count.
// Optional graded-spike output o_graded is enabled by defining OUTPUT_GRADED_EN.
module lif_output_neuron
  import snn_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int DW         = 8,
  parameter int ACC_W      = 12,
  parameter int THRESHOLD  = 100,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRAC_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [N_IN*DW-1:0]   i_data,
  input  logic                 i_clear,
  output logic                 o_valid,
  output logic                 o_spike,
  output logic [ACC_W-1:0]     o_potential,
  output logic [CNT_W-1:0]     o_spike_count
`ifdef OUTPUT_GRADED_EN
  ,
  output logic [ACC_W-1:0]     o_graded
`endif
);

  localparam int SUM_W = sum_w(N_IN, DW);
  localparam int RC_W  = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;
  localparam logic [ACC_W-1:0] THR = ACC_W'(THRESHOLD);

  logic [SUM_W-1:0] sum;

  snn_adder_tree #(.N_IN(N_IN), .DW(DW), .SUM_W(SUM_W)) u_sum (
    .data_i (i_data),
    .sum_o  (sum)
  );

  state_e           state_q, state_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [ACC_W-1:0] v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             spike_q, spike_d;
  logic [ACC_W-1:0] v_leak, v_next;
  logic             fire;
`ifdef OUTPUT_GRADED_EN
  logic [ACC_W-1:0] graded_q, graded_d;
`endif

  // LEAK_SHIFT=0 makes v_leak zero, so the sum fully replaces v.
  assign v_leak = v_q - (v_q >> LEAK_SHIFT);
  assign v_next = ACC_W'(sat_add(32'(v_leak), 32'(sum), ACC_W));
  assign fire   = (v_next >= THR);

  always_comb begin
    state_d  = state_q;
    rc_d     = rc_q;
    v_d      = v_q;
    cnt_d    = cnt_q;
    valid_d  = i_valid;
    spike_d  = 1'b0;
`ifdef OUTPUT_GRADED_EN
    graded_d = '0;
`endif
    if (i_clear) begin
      state_d = ST_INTEGRATE;
      rc_d    = '0;
      v_d     = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_INTEGRATE: begin
          if (i_valid) begin
            if (fire) begin
              spike_d = 1'b1;
              v_d     = '0;
`ifdef OUTPUT_GRADED_EN
              graded_d = v_next;
`endif
              if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
              if (REFRAC_CYC != 0) begin
                state_d = ST_REFRACTORY;
                rc_d    = RC_W'(REFRAC_CYC);
              end
            end else begin
              v_d = v_next;
            end
          end
        end
        ST_REFRACTORY: begin
          // Lane data is dropped here; only the o_valid pulse passes through.
          v_d  = '0;
          rc_d = rc_q - RC_W'(1);
          if (rc_q <= RC_W'(1)) begin
            state_d = ST_INTEGRATE;
            rc_d    = '0;
          end
        end
        default: state_d = ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_INTEGRATE;
      rc_q     <= '0;
      v_q      <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      spike_q  <= 1'b0;
`ifdef OUTPUT_GRADED_EN
      graded_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rc_q     <= rc_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      spike_q  <= spike_d;
`ifdef OUTPUT_GRADED_EN
      graded_q <= graded_d;
`endif
    end
  end

  assign o_valid       = valid_q;
  assign o_spike       = spike_q;
  assign o_potential   = v_q;
  assign o_spike_count = cnt_q;
`ifdef OUTPUT_GRADED_EN
  assign o_graded      = graded_q;
`endif

endmodule
